// File: rtl/i2s_rx_if.sv
`timescale 1ns/1ps
// i2s_rx_if: parallel stereo-pair output bus of the I2S receiver.
// master drives the pair and valid; slave returns ready.
interface i2s_rx_if #(
  parameter int unsigned AUDIO_DW = 16
);
  logic [AUDIO_DW-1:0] left_chan;
  logic [AUDIO_DW-1:0] right_chan;
  logic                valid;
  logic                ready;

  modport master (output left_chan, output right_chan, output valid, input ready);
  modport slave  (input left_chan, input right_chan, input valid, output ready);
endinterface

// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// i2s_rx: oversampled I2S deserialiser in the clk domain.
// Serial inputs are synchronised, bits are taken on the sclk rising edge,
// and completed stereo pairs sit in a single-entry valid/ready register
// with sticky overrun and short-word flags.
// Optional build macro: I2S_RX_LJ_EN selects left-justified attribution
// (bit belongs to the lrclk value sampled with it, no one-bit delay).
module i2s_rx #(
  parameter int unsigned AUDIO_DW = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sclk,
  input  logic     lrclk,
  input  logic     sdata,
  i2s_rx_if.master pcm,
  output logic     overrun,
  output logic     short_word
);

  localparam int unsigned CW = $clog2(AUDIO_DW + 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t              state;
  logic [2:0]          sclk_sync;
  logic [1:0]          lr_sync;
  logic [1:0]          sd_sync;
  logic                bit_stb;
  logic                lr_s;
  logic                sd_s;
`ifndef I2S_RX_LJ_EN
  logic                lr_cap;
`endif
  logic                prev_ch;
  logic [CW-1:0]       cnt;
  logic [AUDIO_DW-1:0] left_word;
  logic [AUDIO_DW-1:0] right_word;

  logic                ch;
  logic                change;
  logic [CW-1:0]       idx;
  logic [CW-1:0]       cnt_next;
  logic [AUDIO_DW-1:0] cur;

  assign bit_stb = sclk_sync[1] & ~sclk_sync[2];
  assign lr_s    = lr_sync[1];
  assign sd_s    = sd_sync[1];

  // Synchronisers run free through reset so a high sclk at reset release
  // does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], sclk};
    lr_sync   <= {lr_sync[0], lrclk};
    sd_sync   <= {sd_sync[0], sdata};
  end

  // Attribute the current bit, pick its index and build the updated word.
  always_comb begin
`ifdef I2S_RX_LJ_EN
    ch = lr_s;
`else
    ch = lr_cap;
`endif
    change = (ch != prev_ch);
    idx    = change ? '0 : cnt;
    cur    = ch ? right_word : left_word;
    if (idx == '0) cur = '0;
    if (idx < CW'(AUDIO_DW))
      cur = cur | (AUDIO_DW'(sd_s) << (CW'(AUDIO_DW - 1) - idx));
    cnt_next = (idx == CW'(AUDIO_DW)) ? idx : idx + CW'(1);
  end

  // Frame FSM: hunt for a right->left boundary, then assemble and emit pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
`ifndef I2S_RX_LJ_EN
      lr_cap         <= 1'b1;
`endif
      prev_ch        <= 1'b1;
      cnt            <= '0;
      left_word      <= '0;
      right_word     <= '0;
      pcm.left_chan  <= '0;
      pcm.right_chan <= '0;
      pcm.valid      <= 1'b0;
      overrun        <= 1'b0;
      short_word     <= 1'b0;
    end else begin
      if (pcm.valid && pcm.ready) pcm.valid <= 1'b0;
      if (bit_stb) begin
`ifndef I2S_RX_LJ_EN
        lr_cap  <= lr_s;
`endif
        prev_ch <= ch;
        cnt     <= cnt_next;
        case (state)
          HUNT: begin
            if (change && !ch) begin
              state     <= RUN;
              left_word <= cur;
            end
          end
          RUN: begin
            if (ch) right_word <= cur;
            else    left_word  <= cur;
            if (change && (cnt < CW'(AUDIO_DW))) short_word <= 1'b1;
            // Emit uses the registered words: the new left bit 0 only lands
            // in left_word at this same edge.
            if (change && !ch) begin
              pcm.left_chan  <= left_word;
              pcm.right_chan <= right_word;
              pcm.valid      <= 1'b1;
              if (pcm.valid && !pcm.ready) overrun <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
